// File: rtl/mux_sel_arbiter_pkg.sv
// Shared types and defaults for the break-before-make mux select arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_sel_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        GRANT,
        DEAD
    } arb_state_t;

    // Dead-time counter width; 8 bits covers the full 1..255 dead-time range.
    localparam int DEAD_CNT_W      = 8;
    localparam int DEAD_CYCLES_DEF = 2;
    localparam int MAX_HOLD_DEF    = 16;

    // Round-robin pick: a lone requester wins; on a tie the one that did not
    // hold the mux last time wins.
    function automatic logic pick_winner(input logic [1:0] req, input logic last);
        logic win;
        win = 1'b0;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = 1'b0;
        endcase
        return win;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the requesting logic and the mux arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until they are done; gnt is the only flow control.
interface mux_sel_arbiter_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       sel;
    logic       out_en;
    logic       busy;

    // Requesting side drives req and observes the arbiter outputs.
    modport master (output req, input gnt, input sel, input out_en, input busy);
    // Arbiter side.
    modport slave  (input req, output gnt, output sel, output out_en, output busy);
endinterface

// File: rtl/mux_sel_arbiter_timer.sv
// Loadable down-counter with a done flag, used to time the dead gap.
// Latency: done asserts load_val_i cycles after a load (immediately for 0).
// Backpressure: none; load_i always wins over counting.
module mux_sel_arbiter_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving a 2:1 mux sel with break-before-make dead time.
// Latency: req -> sel 1 cycle, req -> gnt/out_en 2 cycles; release -> out_en low 1 cycle.
// Backpressure: a grant holds until its req drops (or MAX_HOLD with MUX_SEL_ARBITER_TIMEOUT_EN).
module mux_sel_arbiter
    import mux_sel_arbiter_pkg::*;
#(
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter int MAX_HOLD    = MAX_HOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_arbiter_if.slave   bus
);

    // Parameter range guards, evaluated at elaboration.
    if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_bad_dead
        $error("mux_sel_arbiter: DEAD_CYCLES out of range 1..255");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_hold
        $error("mux_sel_arbiter: MAX_HOLD out of range 2..65535");
    end

    localparam logic [DEAD_CNT_W-1:0] DEAD_LOAD = DEAD_CNT_W'(DEAD_CYCLES - 1);

    arb_state_t state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic [1:0] gnt_q, gnt_d;
    logic       out_en_q, out_en_d;
    logic       busy_q, busy_d;
    logic       dead_load;
    logic       dead_done;
    logic       timeout;

    mux_sel_arbiter_timer #(
        .W (DEAD_CNT_W)
    ) u_dead_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dead_load),
        .load_val_i (DEAD_LOAD),
        .done_o     (dead_done)
    );

`ifdef MUX_SEL_ARBITER_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_q;

    // Hold counter: cleared outside GRANT, so it reads 0 on the first grant cycle.
    always_ff @(posedge clk) begin
        if (rst || state_q != GRANT) begin
            hold_q <= '0;
        end else if (hold_q != HOLD_LAST) begin
            hold_q <= hold_q + 1'b1;
        end
    end

    assign timeout = (state_q == GRANT) && (hold_q == HOLD_LAST) && bus.req[~sel_q];
`else
    // Without the timeout a grant ends only when its own request drops.
    assign timeout = 1'b0;
`endif

    // Next-state, winner selection and registered-output precompute.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        dead_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    state_d = SETUP;
                    sel_d   = pick_winner(bus.req, last_q);
                end
            end
            SETUP: begin
                // An abandoned request never enabled the output, so skip dead time.
                state_d = bus.req[sel_q] ? GRANT : IDLE;
            end
            GRANT: begin
                if (!bus.req[sel_q] || timeout) begin
                    state_d   = DEAD;
                    last_d    = sel_q;
                    dead_load = 1'b1;
                end
            end
            DEAD: begin
                // Requests are only looked at on the final dead cycle.
                if (dead_done) begin
                    if (bus.req != 2'b00) begin
                        state_d = SETUP;
                        sel_d   = pick_winner(bus.req, last_q);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d    = (state_d == GRANT) ? {sel_d, ~sel_d} : 2'b00;
        out_en_d = (state_d == GRANT);
        busy_d   = (state_d != IDLE);
    end

    // State and output registers; reset drops the output with no dead time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            last_q   <= 1'b1;
            gnt_q    <= 2'b00;
            out_en_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            out_en_q <= out_en_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.sel    = sel_q;
    assign bus.out_en = out_en_q;
    assign bus.busy   = busy_q;

endmodule
